mac_sequencer: RTL and testbench

- Micro-sequencer that drives the 5-bit `operacao` input of the datapath control unit `Controle`.
- It runs one complete accumulate-shift-store job: Z = (X summed B times) >> S, i.e. (A*B)>>S, with A already presented to the X register input.
- It sits between the top-level CPU control and `Controle`, replacing hand-driven operation codes with a start/busy/done handshake.

---
 rtl/controle_pkg.sv | 44 ++++
 rtl/step_counter.sv | 31 +++
 rtl/mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_mac_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared definitions for the Controle datapath control unit and its micro-sequencer:
// operation codes, register/ALU control codes and the sequencer state encoding.
package controle_pkg;

  localparam logic [4:0] OP_LOAD  = 5'd0;
  localparam logic [4:0] OP_ACC   = 5'd1;
  localparam logic [4:0] OP_SHR   = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_NOP   = 5'd5;

  // Tx/Ty/Tz register controls and ULA function codes inside Controle.
  localparam logic [1:0] T_HOLD  = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_RESET = 2'd2;
  localparam logic [1:0] T_SHR   = 2'd3;
  localparam logic       ULA_NONE = 1'b0;
  localparam logic       ULA_SUM  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_SHIFT,
    ST_STORE,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  function automatic logic [4:0] state_op(input seq_state_t s);
    case (s)
      ST_LOAD:  return OP_LOAD;
      ST_ACCUM: return OP_ACC;
      ST_SHIFT: return OP_SHR;
      ST_STORE: return OP_STORE;
      default:  return OP_NOP;
    endcase
  endfunction

  function automatic logic state_busy(input seq_state_t s);
    return (s == ST_LOAD) || (s == ST_ACCUM) || (s == ST_SHIFT) ||
           (s == ST_STORE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter that saturates at zero; o_last flags the final counted cycle.
module step_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] r_count;
  logic         w_zero;

  assign w_zero  = (r_count == '0);
  assign o_last  = (r_count == W'(1));
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_count <= r_count - W'(1);
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Drives Controle's operacao input through one LOAD / ACC*B / SHR*S / STORE job,
// then waits PIPE_LAT cycles so Z is valid when done pulses.
module mac_sequencer
  import controle_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SH_W     = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] mult_count,
  input  logic [SH_W-1:0]  shift_count,
  output logic [4:0]       operacao,
  output logic             op_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output seq_state_t       state_dbg
);

  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(PIPE_LAT);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_b;
  logic [SH_W-1:0]  r_s;
  logic [CNT_W-1:0] w_s_ext;
  logic             w_capture;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_last;

  assign w_s_ext   = CNT_W'(r_s);
  assign state_dbg = r_state;

  step_counter #(.W(CNT_W)) u_step_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_count    (steps_left),
    .o_last     (w_cnt_last)
  );

  // Each counted state is entered with its length preloaded and leaves on o_last.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && !(abort && r_state == ST_DONE)) begin
          w_capture = 1'b1;
          w_next    = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (r_b != '0) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = r_b;
          w_next     = ST_ACCUM;
        end else if (r_s != '0) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = w_s_ext;
          w_next     = ST_SHIFT;
        end else begin
          w_next = ST_STORE;
        end
      end
      ST_ACCUM: begin
        if (w_cnt_last && r_s != '0) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = w_s_ext;
          w_next     = ST_SHIFT;
        end else begin
          w_cnt_dec = 1'b1;
          if (w_cnt_last) w_next = ST_STORE;
        end
      end
      ST_SHIFT: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_last) w_next = ST_STORE;
      end
      ST_STORE: begin
        if (PIPE_LAT > 0) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = DRAIN_LEN;
          w_next     = ST_DRAIN;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DRAIN: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_last) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase

    if (abort && state_busy(r_state)) begin
      w_next     = ST_IDLE;
      w_capture  = 1'b0;
      w_cnt_load = 1'b1;
      w_cnt_dec  = 1'b0;
      w_cnt_val  = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      operacao <= OP_NOP;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_b      <= '0;
      r_s      <= '0;
    end else begin
      r_state  <= w_next;
      operacao <= state_op(w_next);
      op_valid <= (state_op(w_next) != OP_NOP);
      busy     <= state_busy(w_next);
      done     <= (w_next == ST_DONE);
      if (w_capture) begin
        r_b <= mult_count;
        r_s <= shift_count;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: hand-computed operacao/busy/done sequences per cycle.
module tb_mac_sequencer;
  import controle_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [7:0]       mult_count;
  logic [3:0]       shift_count;
  logic [4:0]       operacao;
  logic             op_valid;
  logic             busy;
  logic             done;
  logic [7:0]       steps_left;
  seq_state_t       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  mac_sequencer #(.CNT_W(8), .SH_W(4), .PIPE_LAT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .mult_count  (mult_count),
    .shift_count (shift_count),
    .operacao    (operacao),
    .op_valid    (op_valid),
    .busy        (busy),
    .done        (done),
    .steps_left  (steps_left),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cycle(input string tag, input int op, input bit exp_busy, input bit exp_done);
    check({tag, ".op"}, 32'(operacao), 32'(op));
    check({tag, ".valid"}, 32'(op_valid), 32'(op != 5));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  // Checks one job cycle by cycle; the last entry is the done cycle.
  task automatic run_table(input string tag, input int ops[$]);
    int n;
    n = ops.size();
    for (int i = 0; i < n; i++) begin
      exp_cycle($sformatf("%s.c%0d", tag, i + 1), ops[i], i < n - 1, i == n - 1);
      tick();
    end
  endtask

  task automatic start_job(input int b, input int s);
    mult_count  = 8'(b);
    shift_count = 4'(s);
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int q[$];
    int t1_op[9];
    int n_acc, n_shr, done_cyc, acc_first, shr_first, cyc;

    reset = 1'b1; start = 1'b0; abort = 1'b0; mult_count = '0; shift_count = '0;

    // Reset held three cycles, then two idle cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cycle($sformatf("rst%0d", i), 5, 1'b0, 1'b0);
      check("rst.steps", 32'(steps_left), 0);
      check("rst.state", 32'(state_dbg), 32'(ST_IDLE));
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_cycle($sformatf("idle%0d", i), 5, 1'b0, 1'b0);
      check("idle.steps", 32'(steps_left), 0);
    end

    // B=3, S=1; counts changed mid-job must be ignored.
    t1_op = '{0, 1, 1, 1, 3, 4, 5, 5, 5};
    start_job(3, 1);
    for (int c = 1; c <= 9; c++) begin
      exp_cycle($sformatf("t1.c%0d", c), t1_op[c-1], c <= 8, c == 9);
      if (c == 2) begin
        check("t1.steps_c2", 32'(steps_left), 3);
        mult_count  = 8'd7;
        shift_count = 4'd9;
      end
      if (c == 4) check("t1.steps_c4", 32'(steps_left), 1);
      if (c == 5) check("t1.steps_c5", 32'(steps_left), 1);
      tick();
    end
    exp_cycle("t1.after", 5, 1'b0, 1'b0);

    // B=0, S=0: LOAD, STORE, drain, done.
    start_job(0, 0);
    q = '{0, 4, 5, 5, 5};
    run_table("t2", q);
    exp_cycle("t2.after", 5, 1'b0, 1'b0);

    // Abort beats start in DONE.
    start_job(0, 0);
    for (int c = 2; c <= 5; c++) tick();
    check("t2b.done", 32'(done), 1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    exp_cycle("t2b.abort_done", 5, 1'b0, 1'b0);
    tick();
    exp_cycle("t2b.stays_idle", 5, 1'b0, 1'b0);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_cycle("idle_abort", 5, 1'b0, 1'b0);

    // Maximum counts with start pulses ignored while busy.
    n_acc = 0; n_shr = 0; done_cyc = 0; acc_first = -1; shr_first = -1;
    start_job(255, 15);
    cyc = 1;
    while (cyc < 400) begin
      if (operacao == OP_ACC) begin
        if (acc_first < 0) acc_first = int'(steps_left);
        n_acc++;
      end
      if (operacao == OP_SHR) begin
        if (shr_first < 0) shr_first = int'(steps_left);
        n_shr++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc % 37 == 0) && (cyc < 270);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("t3.n_acc", 32'(n_acc), 255);
    check("t3.n_shr", 32'(n_shr), 15);
    check("t3.done_cyc", 32'(done_cyc), 275);
    check("t3.acc_steps", 32'(acc_first), 255);
    check("t3.shr_steps", 32'(shr_first), 15);
    tick();
    exp_cycle("t3.after", 5, 1'b0, 1'b0);

    // Abort in the second ACCUM cycle of B=4, then a clean B=1,S=1 job.
    start_job(4, 0);
    exp_cycle("t4.c1", 0, 1'b1, 1'b0);
    tick();
    exp_cycle("t4.c2", 1, 1'b1, 1'b0);
    tick();
    exp_cycle("t4.c3", 1, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_cycle("t4.aborted", 5, 1'b0, 1'b0);
    check("t4.steps", 32'(steps_left), 0);
    tick();
    exp_cycle("t4.quiet", 5, 1'b0, 1'b0);
    start_job(1, 1);
    q = '{0, 1, 3, 4, 5, 5, 5};
    run_table("t4b", q);

    // Back-to-back: start held through DONE of a B=1,S=0 job.
    mult_count = 8'd1; shift_count = 4'd0; start = 1'b1;
    tick();
    q = '{0, 1, 4, 5, 5, 5, 0};
    for (int c = 1; c <= 7; c++) begin
      exp_cycle($sformatf("t5.c%0d", c), q[c-1], c != 6, c == 6);
      if (c < 7) tick();
    end
    start = 1'b0;
    tick();
    exp_cycle("t5.c8", 1, 1'b1, 1'b0);
    done_cyc = 0;
    for (int c = 9; c < 30; c++) begin
      tick();
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("t5.done2_cyc", 32'(done_cyc), 12);

    // Reset in the middle of SHIFT.
    tick();
    start_job(0, 3);
    exp_cycle("t6.c1", 0, 1'b1, 1'b0);
    tick();
    exp_cycle("t6.c2", 3, 1'b1, 1'b0);
    check("t6.steps_c2", 32'(steps_left), 3);
    tick();
    exp_cycle("t6.c3", 3, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cycle("t6.reset", 5, 1'b0, 1'b0);
    check("t6.steps", 32'(steps_left), 0);
    tick();
    exp_cycle("t6.idle", 5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
